mux_nt1_pipe: RTL and testbench
===============================

MUX_NT1_PIPE -- requirements
Module: mux_nt1_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 4, channel count (2..16).
REQ-003 SHALL have parameter SELW, default 2, select width; N <= 2**SELW.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_bus  input  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SELW  channel select, sampled with in_bus on accept.
REQ-008 SHALL have port in_valid  input  1  upstream offers in_bus/sel.
REQ-009 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  selected channel data.
REQ-011 SHALL have port out_valid  output  1  out_data holds an item.
REQ-012 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-013 SHALL have port sel_err  output  1  sticky out-of-range select flag.

Function
REQ-014 SHALL accept an item when in_valid && in_ready at a rising edge, capturing in_bus[sel*WIDTH +: WIDTH].
REQ-015 SHALL consume the head item when out_valid && out_ready at a rising edge.
REQ-016 SHALL buffer up to two items (main + skid register), three states: EMPTY, ONE, TWO.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO and while rst is high.
REQ-018 SHALL drive out_valid = 1 in ONE and TWO, out_data from the main register.
REQ-019 SHALL transition EMPTY->ONE on accept; ONE->TWO on accept without consume; ONE->EMPTY on consume without accept; ONE->ONE on simultaneous accept and consume, main register loaded with the new item.
REQ-020 SHALL transition TWO->ONE on consume, skid item moved to main register the same edge.
REQ-021 SHALL give latency of one cycle: item accepted at edge k appears on out_data with out_valid after edge k when the buffer was EMPTY.
REQ-022 SHALL sustain one item per cycle when out_ready is held 1, and preserve acceptance order.
REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL ignore in_bus and sel when no accept occurs; a sel change without accept has no effect.
REQ-025 SHALL, for accepted sel >= N, store all-zero data.

Reset
REQ-026 SHALL, on rst assertion, immediately go to EMPTY with out_valid = 0, out_data = 0, sel_err = 0, skid register = 0.
REQ-027 SHALL discard buffered items when reset is asserted mid-operation; no item is delivered after rst.
REQ-028 SHALL accept the first item at the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro MUX_SEL_CHECK_EN defined, set sel_err to 1 on the edge accepting an item with sel >= N and hold it until reset.
REQ-030 SHALL, without MUX_SEL_CHECK_EN, tie sel_err to 0; out-of-range data remains zero per REQ-025.

Verification
REQ-031 SHALL cover: WIDTH=32, N=4, reset released, accept sel=2 with channel 2 = 0xDEADBEEF, out_ready=1 -> out_data 0xDEADBEEF, out_valid=1 after exactly one edge.
REQ-032 SHALL cover: out_ready=0, three back-to-back valid items A,B,C -> A,B accepted, in_ready=0 on the third cycle, C held; out_ready=1 -> A,B,C out in order, no loss.
REQ-033 SHALL cover: continuous in_valid and out_ready=1 for 16 cycles, sel cycling 0..3 -> 16 outputs, one per cycle, in_ready never 0.
REQ-034 SHALL cover: buffer in TWO, rst pulsed mid-cycle -> out_valid=0 and out_data=0 without waiting for a clock edge; no stale item afterwards.
REQ-035 SHALL cover: N=3, SELW=2, accept sel=3 -> out_data=0; sel_err=1 with MUX_SEL_CHECK_EN and staying 1 until reset, 0 without it.

Source files
------------

// File: rtl/mux_nt1_pipe.sv
// mux_nt1_pipe: N-to-1 channel multiplexer with a two-entry elastic output
// buffer (main + skid register). An item is accepted on in_valid && in_ready
// and is presented from the main register on out_data/out_valid until the
// downstream takes it with out_ready. Full throughput is sustained while
// out_ready stays high; the skid register absorbs one item of backpressure.
//
// Parameters:
//   WIDTH  data width per channel
//   N      channel count (2..16)
//   SELW   select width, N <= 2**SELW
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_bus     N channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select, sampled on accept
//   in_valid   upstream offers in_bus/sel
//   in_ready   buffer can accept this cycle (low while rst is high)
//   out_data   head item (main register)
//   out_valid  out_data holds an item
//   out_ready  downstream consumes this cycle
//   sel_err    sticky out-of-range select flag
//
// Build option: define MUX_SEL_CHECK_EN to make sel_err record any accepted
// select >= N until reset; otherwise sel_err is tied low. Out-of-range
// selects always store all-zero data.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no item buffered, out_valid low
// S_ONE   | head item in main register
// S_TWO   | main holds head, skid holds next; in_ready low

module mux_nt1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             consume;

  // Unmatched selects (>= N) fall through to the all-zero default.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) sel_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign in_ready  = (state_q != S_TWO) && !rst;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_d  = sel_data;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          main_d = sel_data;
        end else if (accept) begin
          state_d = S_TWO;
          skid_d  = sel_data;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a consume can happen.
        if (consume) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_oor;
  logic sel_err_q;

  always_comb begin
    sel_oor = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) sel_oor = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nt1_pipe.sv
module tb_mux_nt1_pipe;

  localparam int W = 32;
  localparam int NC = 4;
`ifdef MUX_SEL_CHECK_EN
  localparam bit SE_ON = 1'b1;
`else
  localparam bit SE_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC*W-1:0] in_bus = '0;
  logic [1:0]      sel = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            sel_err;

  // Second instance: N=3 with a 2-bit select, so sel=3 is out of range.
  logic            rst3 = 1'b1;
  logic [23:0]     bus3 = '0;
  logic [1:0]      sel3 = '0;
  logic            v3 = 1'b0;
  logic            ir3;
  logic [7:0]      od3;
  logic            ov3;
  logic            or3 = 1'b0;
  logic            se3;

  mux_nt1_pipe #(.WIDTH(W), .N(NC), .SELW(2)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nt1_pipe #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst3), .in_bus(bus3), .sel(sel3), .in_valid(v3),
    .in_ready(ir3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .sel_err(se3)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO of at most two items, plus a log of delivered items.
  logic [W-1:0] mq[$];
  logic [W-1:0] delivered[$];
  bit acc, con;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [NC*W-1:0] bus, input logic [1:0] s);
    if (int'(s) >= NC) return '0;
    return bus[int'(s)*W +: W];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      acc = in_valid && (mq.size() < 2);
      con = out_ready && (mq.size() > 0);
      if (con) delivered.push_back(mq.pop_front());
      if (acc) mq.push_back(pick(in_bus, sel));
    end
  end

  always @(posedge rst) mq.delete();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!rst && mq.size() < 2)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (!rst && mq.size() > 0)});
      if (rst) chk("out_data_rst", {32'd0, out_data}, 64'd0);
      else if (mq.size() > 0) chk("out_data", {32'd0, out_data}, {32'd0, mq[0]});
      chk("sel_err", {63'd0, sel_err}, 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic rand_bus();
    for (int k = 0; k < NC; k++) in_bus[k*W +: W] = $urandom;
  endtask

  int ir_low;
  int ov_cnt;

  initial begin
    @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
    chk_en = 1'b1;

    // Single item, one-cycle latency.
    rand_bus();
    in_bus[2*W +: W] = 32'hDEADBEEF;
    sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("lat_pre_valid", {63'd0, out_valid}, 64'd0);
    cyc();
    chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_out_data", {32'd0, out_data}, 64'hDEADBEEF);
    in_valid = 1'b0;
    cyc();
    chk("lat_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: A,B fill the buffer, C waits, then all drain in order.
    delivered.delete();
    in_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    cyc();
    sel = 2'd3;
    cyc();
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    sel = 2'd0;
    cyc();
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head", {32'd0, out_data}, 64'h22222222);
    out_ready = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("bp_count", delivered.size(), 64'd3);
    if (delivered.size() == 3) begin
      chk("bp_item0", {32'd0, delivered[0]}, 64'h22222222);
      chk("bp_item1", {32'd0, delivered[1]}, 64'h44444444);
      chk("bp_item2", {32'd0, delivered[2]}, 64'h11111111);
    end

    // Streaming: 16 back-to-back items with out_ready held high.
    delivered.delete();
    ir_low = 0;
    ov_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rand_bus();
      sel = 2'(i % 4);
      in_valid = 1'b1;
      if (in_ready !== 1'b1) ir_low++;
      cyc();
      if (out_valid === 1'b1) ov_cnt++;
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_ready_low", ir_low, 64'd0);
    chk("stream_valid_cnt", ov_cnt, 64'd16);
    chk("stream_delivered", delivered.size(), 64'd16);

    // Reset while TWO items are buffered.
    rand_bus();
    sel = 2'd0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    cyc();
    cyc();
    chk("two_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    rand_bus();
    in_bus[1*W +: W] = 32'h0BADCAFE;
    sel = 2'd1;
    in_valid = 1'b1;
    rst = 1'b0;
    cyc();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_data", {32'd0, out_data}, 64'h0BADCAFE);
    in_valid = 1'b0;
    cyc();
    chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 400; i++) begin
      rand_bus();
      sel = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rand_drained", {63'd0, out_valid}, 64'd0);

    // Out-of-range select on the N=3 instance.
    bus3 = {8'h33, 8'h22, 8'h11};
    sel3 = 2'd3;
    v3 = 1'b1;
    or3 = 1'b1;
    rst3 = 1'b0;
    cyc();
    chk("oor_valid", {63'd0, ov3}, 64'd1);
    chk("oor_data", {56'd0, od3}, 64'd0);
    chk("oor_sel_err", {63'd0, se3}, {63'd0, SE_ON});
    sel3 = 2'd1;
    cyc();
    chk("n3_data", {56'd0, od3}, 64'h22);
    chk("n3_sel_err_sticky", {63'd0, se3}, {63'd0, SE_ON});
    v3 = 1'b0;
    cyc();
    cyc();
    chk("n3_sel_err_hold", {63'd0, se3}, {63'd0, SE_ON});
    chk("n3_ready", {63'd0, ir3}, 64'd1);
    rst3 = 1'b1;
    #1;
    chk("n3_rst_sel_err", {63'd0, se3}, 64'd0);
    chk("n3_rst_valid", {63'd0, ov3}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
